// File: rtl/register_file_param.sv
// Parametrised multi-port register file with hardwired low constants, byte-masked writes,
// optional write-to-read bypass, a pending-load scoreboard and a registered illegal-write flag.
module register_file_param #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NUM_CONST = 3,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wen,
    input  logic [AW-1:0]        wsel,
    input  logic [WIDTH/8-1:0]   wmask,
    input  logic [WIDTH-1:0]     in,
    input  logic [AW-1:0]        asel,
    input  logic [AW-1:0]        bsel,
    input  logic [AW-1:0]        csel,
    output logic [WIDTH-1:0]     out1,
    output logic [WIDTH-1:0]     out0,
    output logic [WIDTH-1:0]     outC,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_sel,
    output logic                 a_busy,
    output logic                 b_busy,
    output logic                 c_busy,
    output logic                 werr
);

    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             werr_q, werr_d;

    logic             wr_ok;
    logic             wr_bad;
    logic             set_ok;
    logic [WIDTH-1:0] wr_word;

    // True for selects that address real, writable storage.
    function automatic logic sel_rw(input logic [AW-1:0] sel);
        return (32'(sel) >= NUM_CONST) && (32'(sel) < DEPTH);
    endfunction

    // Everything is gated by reset so nothing leaks through the bypass while in reset.
    assign wr_ok  = reset && wen && sel_rw(wsel) && (wmask != '0);
    assign wr_bad = reset && wen && !sel_rw(wsel);
    assign set_ok = reset && busy_set && sel_rw(busy_sel);

    always_comb begin
        wr_word = mem_q[IW'(wsel)];
        for (int k = 0; k < NB; k++) begin
            if (wmask[k]) begin
                wr_word[8*k +: 8] = in[8*k +: 8];
            end
        end
    end

    function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] sel);
        if (32'(sel) < NUM_CONST) begin
            return WIDTH'(sel);
        end
        if (32'(sel) >= DEPTH) begin
            return '0;
        end
        if (BYPASS && wr_ok && (sel == wsel)) begin
            return wr_word;
        end
        return mem_q[IW'(sel)];
    endfunction

    // A same-cycle write hides the stored bit unless a new load is issued alongside it.
    function automatic logic rd_busy(input logic [AW-1:0] sel);
        if (!sel_rw(sel)) begin
            return 1'b0;
        end
        if (BYPASS && wr_ok && (sel == wsel)) begin
            return set_ok && (busy_sel == sel);
        end
        return busy_q[IW'(sel)];
    endfunction

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        werr_d = wr_bad;
        if (wr_ok) begin
            mem_d[IW'(wsel)]  = wr_word;
            busy_d[IW'(wsel)] = 1'b0;
        end
        if (set_ok) begin
            busy_d[IW'(busy_sel)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
            werr_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            werr_q <= werr_d;
        end
    end

    always_comb begin
        out1   = rd_data(asel);
        out0   = rd_data(bsel);
        outC   = rd_data(csel);
        a_busy = rd_busy(asel);
        b_busy = rd_busy(bsel);
        c_busy = rd_busy(csel);
        werr   = werr_q;
    end

endmodule

// File: tb/tb_register_file_param.sv
// Randomised and directed bench for register_file_param: a 32-bit bypassing instance and a
// 64-bit non-bypassing instance, both checked every cycle against an array-based model.
module tb_register_file_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=32 DEPTH=32 AW=6 NUM_CONST=3 BYPASS=1
    logic        a_wen, a_set, a_ab, a_bb, a_cb, a_werr;
    logic [5:0]  a_wsel, a_asel, a_bsel, a_csel, a_bsl;
    logic [3:0]  a_wmask;
    logic [31:0] a_in, a_out1, a_out0, a_outc;
    // Instance 1: WIDTH=64 DEPTH=16 AW=4 NUM_CONST=1 BYPASS=0
    logic        b_wen, b_set, b_ab, b_bb, b_cb, b_werr;
    logic [3:0]  b_wsel, b_asel, b_bsel, b_csel, b_bsl;
    logic [7:0]  b_wmask;
    logic [63:0] b_in, b_out1, b_out0, b_outc;

    register_file_param #(
        .WIDTH(32), .DEPTH(32), .AW(6), .NUM_CONST(3), .BYPASS(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(rst_n), .wen(a_wen), .wsel(a_wsel), .wmask(a_wmask), .in(a_in),
        .asel(a_asel), .bsel(a_bsel), .csel(a_csel), .out1(a_out1), .out0(a_out0),
        .outC(a_outc), .busy_set(a_set), .busy_sel(a_bsl), .a_busy(a_ab), .b_busy(a_bb),
        .c_busy(a_cb), .werr(a_werr)
    );

    register_file_param #(
        .WIDTH(64), .DEPTH(16), .AW(4), .NUM_CONST(1), .BYPASS(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(rst_n), .wen(b_wen), .wsel(b_wsel), .wmask(b_wmask), .in(b_in),
        .asel(b_asel), .bsel(b_bsel), .csel(b_csel), .out1(b_out1), .out0(b_out0),
        .outC(b_outc), .busy_set(b_set), .busy_sel(b_bsl), .a_busy(b_ab), .b_busy(b_bb),
        .c_busy(b_cb), .werr(b_werr)
    );

    typedef struct {
        bit        wen;
        int        wsel;
        bit [7:0]  wmask;
        bit [63:0] din;
        int        sa, sb, sc;
        bit        bset;
        int        bsel;
    } stim_t;

    stim_t       st [2];
    logic [63:0] mmem [2][32];
    bit          mbusy [2][32];
    bit          mwerr [2];
    logic [63:0] cap_o1 [2], cap_o0 [2], cap_oc [2];
    logic        cap_ab [2], cap_bb [2], cap_cb [2], cap_we [2];
    int          checks = 0;
    int          errors = 0;

    function automatic int dep(int d);    return (d == 0) ? 32 : 16;   endfunction
    function automatic int nc(int d);     return (d == 0) ? 3 : 1;     endfunction
    function automatic int nbytes(int d); return (d == 0) ? 4 : 8;     endfunction
    function automatic bit bp(int d);     return d == 0;               endfunction
    function automatic bit valid_rw(int d, int sel);
        return sel >= nc(d) && sel < dep(d);
    endfunction

    // ---------------- behavioural model ----------------
    function automatic bit m_legal(int d);
        bit [7:0] m = (d == 0) ? (st[d].wmask & 8'h0F) : st[d].wmask;
        return rst_n && st[d].wen && valid_rw(d, st[d].wsel) && (m != 0);
    endfunction

    function automatic logic [63:0] m_merged(int d);
        logic [63:0] v = mmem[d][st[d].wsel];
        for (int k = 0; k < nbytes(d); k++) begin
            if (st[d].wmask[k]) v[8*k +: 8] = st[d].din[8*k +: 8];
        end
        return v;
    endfunction

    function automatic logic [63:0] m_read(int d, int sel);
        if (sel < nc(d)) return 64'(sel);
        if (sel >= dep(d)) return 64'h0;
        if (bp(d) && m_legal(d) && sel == st[d].wsel) return m_merged(d);
        return mmem[d][sel];
    endfunction

    function automatic bit m_busy(int d, int sel);
        if (!valid_rw(d, sel)) return 1'b0;
        if (bp(d) && m_legal(d) && sel == st[d].wsel)
            return rst_n && st[d].bset && st[d].bsel == sel;
        return mbusy[d][sel];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                mmem[d][i]  = 64'h0;
                mbusy[d][i] = 1'b0;
            end
            mwerr[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit legal = m_legal(d);
            logic [63:0] nw = legal ? m_merged(d) : 64'h0;
            mwerr[d] = st[d].wen && !valid_rw(d, st[d].wsel);
            if (legal) begin
                mmem[d][st[d].wsel]  = nw;
                mbusy[d][st[d].wsel] = 1'b0;
            end
            if (st[d].bset && valid_rw(d, st[d].bsel)) mbusy[d][st[d].bsel] = 1'b1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                cap_o1[d] = 64'(a_out1); cap_o0[d] = 64'(a_out0); cap_oc[d] = 64'(a_outc);
                cap_ab[d] = a_ab; cap_bb[d] = a_bb; cap_cb[d] = a_cb; cap_we[d] = a_werr;
            end else begin
                cap_o1[d] = b_out1; cap_o0[d] = b_out0; cap_oc[d] = b_outc;
                cap_ab[d] = b_ab; cap_bb[d] = b_bb; cap_cb[d] = b_cb; cap_we[d] = b_werr;
            end
            check($sformatf("d%0d out1 sel=%0d", d, st[d].sa), cap_o1[d], m_read(d, st[d].sa));
            check($sformatf("d%0d out0 sel=%0d", d, st[d].sb), cap_o0[d], m_read(d, st[d].sb));
            check($sformatf("d%0d outC sel=%0d", d, st[d].sc), cap_oc[d], m_read(d, st[d].sc));
            check($sformatf("d%0d a_busy sel=%0d", d, st[d].sa), 64'(cap_ab[d]),
                  64'(m_busy(d, st[d].sa)));
            check($sformatf("d%0d b_busy sel=%0d", d, st[d].sb), 64'(cap_bb[d]),
                  64'(m_busy(d, st[d].sb)));
            check($sformatf("d%0d c_busy sel=%0d", d, st[d].sc), 64'(cap_cb[d]),
                  64'(m_busy(d, st[d].sc)));
            check($sformatf("d%0d werr", d), 64'(cap_we[d]), 64'(mwerr[d]));
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic idle(int d);
        st[d] = '{wen: 1'b0, wsel: 0, wmask: 8'h0, din: 64'h0, sa: 0, sb: 0, sc: 0,
                  bset: 1'b0, bsel: 0};
    endtask

    task automatic rand_stim(int d);
        int mx = (d == 0) ? 40 : 15;
        st[d].wen   = ($urandom_range(0, 3) != 0);
        st[d].wsel  = $urandom_range(0, mx);
        st[d].wmask = (d == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        st[d].din   = {$urandom, $urandom};
        st[d].sa    = ($urandom_range(0, 3) == 0) ? st[d].wsel : $urandom_range(0, mx);
        st[d].sb    = ($urandom_range(0, 3) == 0) ? st[d].wsel : $urandom_range(0, mx);
        st[d].sc    = ($urandom_range(0, 3) == 0) ? st[d].sa : $urandom_range(0, mx);
        st[d].bset  = ($urandom_range(0, 2) == 0);
        st[d].bsel  = ($urandom_range(0, 2) == 0) ? st[d].wsel : $urandom_range(0, mx);
    endtask

    task automatic drive();
        a_wen = st[0].wen; a_wsel = 6'(st[0].wsel); a_wmask = st[0].wmask[3:0];
        a_in = st[0].din[31:0]; a_asel = 6'(st[0].sa); a_bsel = 6'(st[0].sb);
        a_csel = 6'(st[0].sc); a_set = st[0].bset; a_bsl = 6'(st[0].bsel);
        b_wen = st[1].wen; b_wsel = 4'(st[1].wsel); b_wmask = st[1].wmask;
        b_in = st[1].din; b_asel = 4'(st[1].sa); b_bsel = 4'(st[1].sb);
        b_csel = 4'(st[1].sc); b_set = st[1].bset; b_bsl = 4'(st[1].bsel);
    endtask

    // One cycle: drive after the falling edge, check, then advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        drive();
        #1;
        compare_all();
        @(posedge clk);
        if (rst_n) model_edge();
    endtask

    task automatic wr(int d, int sel, logic [63:0] din, bit [7:0] mask);
        st[d].wen = 1'b1; st[d].wsel = sel; st[d].din = din; st[d].wmask = mask;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle(0); idle(1); drive();
        model_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        step(); step();
        #2 rst_n = 1'b1;

        // Reset and constants
        idle(0); wr(0, 5, 64'hDEADBEEF, 8'hF); st[0].bset = 1'b1; st[0].bsel = 5;
        step();
        idle(0); st[0].sa = 5; st[0].sb = 1; st[0].sc = 2;
        step();
        check("pin r5 before reset", cap_o1[0], 64'hDEADBEEF);
        check("pin r5 busy before reset", 64'(cap_ab[0]), 64'h1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        check("pin r5 in reset", cap_o1[0], 64'h0);
        check("pin r1 const", cap_o0[0], 64'h1);
        check("pin r2 const", cap_oc[0], 64'h2);
        check("pin werr in reset", 64'(cap_we[0]), 64'h0);
        check("pin busy in reset", 64'(cap_ab[0]), 64'h0);
        wr(0, 5, 64'hFFFFFFFF, 8'hF);
        step();
        check("pin no bypass in reset", cap_o1[0], 64'h0);
        step();
        #2 rst_n = 1'b1;
        step();
        check("pin first write after reset", cap_o1[0], 64'hFFFFFFFF);

        // Masked write (instance 0) and 64-bit sweep (instance 1)
        idle(0); idle(1);
        wr(0, 7, 64'h11223344, 8'hF);
        wr(1, 15, 64'h0123456789ABCDEF, 8'hFF);
        step();
        check("pin wide r0", cap_o1[1], 64'h0);
        wr(0, 7, 64'hAABBCCDD, 8'h5); st[0].sb = 7;
        wr(1, 15, 64'hFFFFFFFFFFFFFFFF, 8'h81); st[1].sa = 15;
        step();
        check("pin wide old value", cap_o1[1], 64'h0123456789ABCDEF);
        idle(0); idle(1); st[0].sb = 7; st[1].sa = 15;
        step();
        check("pin masked r7", cap_o0[0], 64'h11BB33DD);
        check("pin wide masked r15", cap_o1[1], 64'hFF23456789ABCDFF);

        // Bypass vs no bypass
        idle(0); idle(1);
        wr(0, 9, 64'h12345678, 8'hF); st[0].sa = 9;
        wr(1, 9, 64'h12345678, 8'hFF); st[1].sa = 9;
        step();
        check("pin bypass out1", cap_o1[0], 64'h12345678);
        check("pin no-bypass old", cap_o1[1], 64'h0);
        idle(0); idle(1); st[0].sa = 9; st[1].sa = 9;
        step();
        check("pin no-bypass new", cap_o1[1], 64'h12345678);

        // Illegal writes, back to back
        idle(1);
        idle(0); wr(0, 1, 64'hFFFFFFFF, 8'hF); st[0].sa = 1;
        step();
        check("pin r1 unchanged", cap_o1[0], 64'h1);
        idle(0); wr(0, 40, 64'h55, 8'hF); st[0].sa = 1;
        step();
        check("pin werr after r1", 64'(cap_we[0]), 64'h1);
        idle(0); wr(0, 20, 64'h77, 8'h0); st[0].sa = 40;
        step();
        check("pin werr after r40", 64'(cap_we[0]), 64'h1);
        check("pin out of range read", cap_o1[0], 64'h0);
        idle(0); st[0].sa = 20;
        step();
        check("pin werr after mask0", 64'(cap_we[0]), 64'h0);
        check("pin mask0 no-op", cap_o1[0], 64'h0);

        // Scoreboard
        idle(0); st[0].bset = 1'b1; st[0].bsel = 12; st[0].sc = 12;
        step();
        check("pin busy not yet", 64'(cap_cb[0]), 64'h0);
        idle(0); st[0].sc = 12;
        step();
        check("pin busy set", 64'(cap_cb[0]), 64'h1);
        idle(0); wr(0, 12, 64'h5, 8'h1); st[0].sc = 12;
        step();
        check("pin busy bypass clear", 64'(cap_cb[0]), 64'h0);
        idle(0); st[0].sc = 12;
        step();
        check("pin busy cleared", 64'(cap_cb[0]), 64'h0);
        idle(0); wr(0, 12, 64'h6, 8'hF); st[0].bset = 1'b1; st[0].bsel = 12; st[0].sc = 12;
        step();
        check("pin set wins same cycle", 64'(cap_cb[0]), 64'h1);
        idle(0); st[0].sc = 12;
        step();
        check("pin set wins after edge", 64'(cap_cb[0]), 64'h1);

        // Random traffic with an asynchronous reset in the middle
        for (int n = 0; n < 600; n++) begin
            rand_stim(0); rand_stim(1);
            step();
            if (n == 300) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 compare_all();
                rand_stim(0); rand_stim(1);
                step();
                #2 rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the fixed 32x32 three-read-port register file in the CPU datapath.
- Generalises width and depth, and keeps the low constant registers, which are hardwired to their own index.
- New capabilities:
  - byte-masked writes
  - optional same-cycle write-to-read bypass
  - a per-register pending-load scoreboard, so the control unit can stall on operands still in flight
  - a registered error flag for illegal writes

Parameters:
- WIDTH, 32: data width in bits. Must be a multiple of 8.
- DEPTH, 32: number of architectural registers. Must be at least NUM_CONST+1.
- AW, 5: select width. Must be at least clog2(DEPTH).
- NUM_CONST, 3: registers 0..NUM_CONST-1 are read-only constants. Each reads as its own index, zero-extended to WIDTH.
- BYPASS, 1: when 1, reads see same-cycle write data and the write's scoreboard clear. When 0, reads see stored state only.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wen  in  1  write enable.
- wsel  in  AW  write register select.
- wmask  in  WIDTH/8  byte enables for the write. Bit k covers in[8k+7:8k].
- in  in  WIDTH  write data.
- asel, bsel, csel  in  AW each  read selects.
- out1, out0, outC  out  WIDTH each  read data for asel, bsel and csel respectively.
- busy_set  in  1  marks a register as having a pending load.
- busy_sel  in  AW  register to mark.
- a_busy, b_busy, c_busy  out  1 each  pending-load status of asel, bsel and csel.
- werr  out  1  registered one-cycle pulse flagging an illegal write.

Behaviour:
- Write legality: a write is legal when wen=1, NUM_CONST <= wsel < DEPTH, and wmask != 0.
- Legal write: at the rising clk edge, only the bytes whose wmask bit is set are updated; unmasked bytes hold their value.
- Illegal write, case 1: wen=1 with wsel < NUM_CONST or wsel >= DEPTH. Storage is unchanged and werr=1 for exactly the next cycle.
- Illegal write, case 2: wen=1 with wmask=0. This is a no-op and does not raise werr.
- werr behaviour: back-to-back illegal writes hold werr high on consecutive cycles.
- Reads: combinational, zero cycles of latency.
  - sel < NUM_CONST returns the value sel.
  - sel >= DEPTH returns 0.
  - Otherwise returns the stored value.
- Bypass (BYPASS=1): if a read select equals the wsel of a legal write in the same cycle, the output is the merged word: masked bytes from in, the rest from stored.
- Bypass disabled (BYPASS=0): the output is the stored value, and the new value appears from the next cycle.
- Scoreboard: one busy bit per non-constant register.
  - busy_set=1 with a valid, non-constant busy_sel sets the bit at the clk edge.
  - busy_set to a constant or out-of-range register is ignored, with no werr.
  - A legal write to a register clears its bit at the clk edge, whatever the mask.
  - A busy_set and a legal write to the same register in the same cycle leave the bit set (set wins, because a new load was issued).
- Busy outputs: x_busy = busy[xsel], and is 0 for constant or out-of-range selects.
  - With BYPASS=1, x_busy is 0 when a legal write to xsel occurs in the same cycle.
  - If a busy_set to the same register also occurs in that cycle, x_busy reads 1.
- Reset (reset=0): asynchronous and effective immediately, including mid-operation.
  - All non-constant registers go to 0, all busy bits to 0, and werr to 0.
  - Outputs reflect the reset state combinationally.
  - Writes and busy_set are ignored while reset=0. The first write is accepted at the first clk edge after reset deasserts.
- Simultaneous events:
  - Any mix of read ports may select the same register; all return identical data.
  - Write and busy_set to different registers both take effect.

Test Plan:
- Reset and constants: assert reset=0 mid-stream after writing r5=0xDEADBEEF. Required: out1 for asel=5 reads 0 immediately; asel=0,1,2 read 0,1,2; werr=0; all busy outputs 0.
- Masked write: r7=0x11223344, then write in=0xAABBCCDD with wmask=0101. Required: r7=0x11BB33DD next cycle; bsel=7 returns 0x11BB33DD.
- Bypass: BYPASS=1, wen=1, wsel=9, in=0x12345678, full mask, asel=9 in the same cycle. Required: out1=0x12345678 that cycle. With BYPASS=0, out1 shows the old value and then 0x12345678 one cycle later.
- Illegal write: wen=1, wsel=1, in=0xFFFFFFFF. Required: r1 still reads 1; werr=1 for exactly one cycle after the edge, then 0. wsel=40 with DEPTH=32 also raises werr.
- Scoreboard: busy_set for r12, then csel=12. Required: c_busy=1 from the next cycle. A later legal write to r12 gives c_busy=0 in that cycle (bypass) and the bit is clear after the edge. busy_set and write to r12 in the same cycle leave c_busy=1.
- Parameter sweep: WIDTH=64, DEPTH=16, AW=4, NUM_CONST=1. Required: r0 reads 0; 64-bit masked writes are correct; sel=15 is writable.
